sar_search: RTL and testbench
=============================

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 4, bit width of probe, result and search range 0..2^WIDTH-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new search; sampled in IDLE only.
REQ-005 abort  input  1  synchronous cancel of a search in progress.
REQ-006 gt_in  input  1  comparator answer: hidden target T strictly greater than probe.
REQ-007 gt_valid  input  1  gt_in is valid for the current probe this cycle.
REQ-008 probe  output  WIDTH  registered candidate driven to the external greater-than comparator.
REQ-009 probe_valid  output  1  probe is stable and awaiting an answer.
REQ-010 busy  output  1  search in progress.
REQ-011 done  output  1  one-cycle pulse: result just updated.
REQ-012 result  output  WIDTH  last completed search value, held until the next completion.

Function
REQ-013 The block SHALL recover T by successive approximation, MSB first, using only "T > probe" answers.
REQ-014 FSM states SHALL be IDLE, SEARCH, DONE; reset state IDLE.
REQ-015 IDLE -> SEARCH on start=1 and abort=0; acc cleared to 0, bit index k loaded with WIDTH-1.
REQ-016 In SEARCH, probe SHALL equal ((acc | 2^k) - 1) modulo 2^WIDTH; the trial value is never 0, so no underflow occurs.
REQ-017 probe_valid SHALL be 1 throughout SEARCH; probe SHALL stay constant until a cycle with gt_valid=1.
REQ-018 On gt_valid=1 in SEARCH: gt_in=1 sets bit k of acc; gt_in=0 leaves it clear.
REQ-019 If k>0, k decrements and the next probe appears the following cycle; if k=0, go to DONE.
REQ-020 DONE SHALL last exactly one cycle: result <= final acc, done=1, busy=0, probe_valid=0; then go to IDLE.
REQ-021 With gt_valid tied high, the latency from the start cycle to the done pulse SHALL be WIDTH+1 cycles.
REQ-022 busy SHALL equal 1 exactly in SEARCH.
REQ-023 gt_valid and gt_in SHALL be ignored outside SEARCH.
REQ-024 start SHALL be ignored in SEARCH and in DONE; start in the IDLE cycle following DONE begins a new search.
REQ-025 abort=1 in SEARCH SHALL return the FSM to IDLE next cycle. The following SHALL hold:
  - result unchanged
  - no done pulse
  - probe_valid=0
REQ-026 abort SHALL take priority over start and over a simultaneous gt_valid.
REQ-027 In IDLE, probe SHALL hold 0.

Reset
REQ-028 Asserting rst at any time, including mid-search, SHALL immediately force the following:
  - state IDLE
  - acc, k, probe and result to 0
  - probe_valid, busy and done to 0
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-030 A shared package SHALL hold:
  - the state enumeration (IDLE, SEARCH, DONE)
  - the WIDTH default constant
REQ-031 No sub-module SHALL be used.
  - The bit-index counter and acc register are inline.
  - The comparator stays external.
REQ-032 The bench SHALL close the loop with the team's existing 4-bit greater-than comparator: probe as one operand, T as the other.

Verification
REQ-033 T=11, gt_valid=1, start pulse -> probes 7, 11, 9, 10; done at cycle 5; result=11.
REQ-034 T=0 and T=15 -> probes 7,3,1,0 giving result 0; probes 7,11,13,14 giving result 15; no wraparound.
REQ-035 T=6, gt_valid delayed 3 cycles per probe -> probe stable while waiting; probes 7,3,5,6; result=6; total latency 17 cycles.
REQ-036 abort together with gt_valid on the second probe -> IDLE next cycle; result keeps the prior value; no done pulse; a following start succeeds.
REQ-037 rst asserted during SEARCH with T=9 -> all outputs 0 asynchronously; a new start after release gives result 9.
REQ-038 Exhaustive: all 16 T values back-to-back with start re-asserted in each IDLE cycle -> result=T every run; start during busy ignored.

Source files
------------

// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search block:
// FSM state encoding and the default data width.
package sar_search_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search_if.sv
// Probe/answer bus between the search engine and its external comparator.
// Handshake: the engine holds probe stable while probe_valid=1 and advances only on a cycle with gt_valid=1.
interface sar_search_if
  import sar_search_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic             abort;
  logic             gt_in;
  logic             gt_valid;
  logic [WIDTH-1:0] probe;
  logic             probe_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  state_t           state;

  modport master (
    output start, abort, gt_in, gt_valid,
    input  probe, probe_valid, busy, done, result, state
  );

  modport slave (
    input  start, abort, gt_in, gt_valid,
    output probe, probe_valid, busy, done, result, state
  );

endinterface

// File: rtl/sar_search.sv
// Successive-approximation recovery of a hidden value T, MSB first, from
// "T > probe" answers supplied by an external comparator.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  sar_search_if.slave bus
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] probe_r;
  logic [WIDTH-1:0] result_r;
  logic             probe_valid_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] acc_next;
  logic [KW-1:0]    k_dec;
  logic [WIDTH-1:0] probe_next;

  // Probe is (trial - 1) so that "T > probe" is the same as "T >= trial".
  always_comb begin
    bit_k      = WIDTH'(1) << k;
    acc_next   = bus.gt_in ? (acc | bit_k) : acc;
    k_dec      = k - KW'(1);
    probe_next = (acc_next | (WIDTH'(1) << k_dec)) - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      k             <= '0;
      probe_r       <= '0;
      result_r      <= '0;
      probe_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start && !bus.abort) begin
            state         <= SEARCH;
            acc           <= '0;
            k             <= KW'(WIDTH - 1);
            probe_r       <= (WIDTH'(1) << (WIDTH - 1)) - WIDTH'(1);
            probe_valid_r <= 1'b1;
            busy_r        <= 1'b1;
          end
        end
        SEARCH: begin
          if (bus.abort) begin
            state         <= IDLE;
            probe_r       <= '0;
            probe_valid_r <= 1'b0;
            busy_r        <= 1'b0;
          end else if (bus.gt_valid) begin
            acc <= acc_next;
            if (k != '0) begin
              k       <= k_dec;
              probe_r <= probe_next;
            end else begin
              state         <= DONE;
              result_r      <= acc_next;
              done_r        <= 1'b1;
              busy_r        <= 1'b0;
              probe_valid_r <= 1'b0;
              probe_r       <= '0;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.probe       = probe_r;
  assign bus.probe_valid = probe_valid_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result      = result_r;
  assign bus.state       = state;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: closes the loop through a 4-bit greater-than
// comparator against a hidden target and checks probes, timing and results.
module tb_sar_search;
  import sar_search_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] target;
  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];

  sar_search_if #(.WIDTH(4)) sif ();

  sar_search #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  // External comparator: hidden target on one side, probe on the other.
  assign sif.gt_in = (target > sif.probe);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full search; probes come from exp_q, dly = idle cycles before each answer.
  task automatic do_search(input logic [3:0] t, input int dly,
                           input logic [3:0] exp_res, input int exp_lat);
    int n;
    logic [3:0] ep;
    target       = t;
    sif.abort    = 1'b0;
    sif.start    = 1'b1;
    sif.gt_valid = (dly == 0);
    step();
    n = 1;
    sif.start = 1'b0;
    chk("busy_in_search", 32'(sif.busy), 1);
    chk("state_search", 32'(sif.state), 32'(SEARCH));
    for (int i = 0; i < 4; i++) begin
      ep = exp_q.pop_front();
      for (int w = 0; w < dly; w++) begin
        sif.gt_valid = 1'b0;
        chk("probe_wait", 32'(sif.probe), 32'(ep));
        step();
        n++;
      end
      sif.gt_valid = 1'b1;
      chk("probe", 32'(sif.probe), 32'(ep));
      chk("probe_valid", 32'(sif.probe_valid), 1);
      step();
      n++;
    end
    sif.gt_valid = 1'b0;
    chk("done_pulse", 32'(sif.done), 1);
    chk("busy_in_done", 32'(sif.busy), 0);
    chk("pv_in_done", 32'(sif.probe_valid), 0);
    chk("result", 32'(sif.result), 32'(exp_res));
    chk("latency", 32'(n), 32'(exp_lat));
    step();
    chk("done_one_cycle", 32'(sif.done), 0);
    chk("probe_idle", 32'(sif.probe), 0);
    chk("state_idle", 32'(sif.state), 32'(IDLE));
  endtask

  initial begin
    rst          = 1'b1;
    target       = 4'd0;
    sif.start    = 1'b0;
    sif.abort    = 1'b0;
    sif.gt_valid = 1'b0;
    step();
    step();
    chk("rst_probe", 32'(sif.probe), 0);
    chk("rst_pv", 32'(sif.probe_valid), 0);
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_done", 32'(sif.done), 0);
    chk("rst_result", 32'(sif.result), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic search, answers every cycle; start accepted on the first edge after reset.
    exp_q = '{4'd7, 4'd11, 4'd9, 4'd10};
    do_search(4'd11, 0, 4'd11, 5);

    // Range boundaries.
    exp_q = '{4'd7, 4'd3, 4'd1, 4'd0};
    do_search(4'd0, 0, 4'd0, 5);
    exp_q = '{4'd7, 4'd11, 4'd13, 4'd14};
    do_search(4'd15, 0, 4'd15, 5);

    // Slow comparator: three idle cycles before each answer.
    exp_q = '{4'd7, 4'd3, 4'd5, 4'd6};
    do_search(4'd6, 3, 4'd6, 17);

    // Abort beats start in IDLE.
    sif.start    = 1'b1;
    sif.abort    = 1'b1;
    sif.gt_valid = 1'b1;
    step();
    chk("idle_abort_start_busy", 32'(sif.busy), 0);
    chk("idle_abort_start_result", 32'(sif.result), 6);
    sif.start    = 1'b0;
    sif.abort    = 1'b0;

    // Abort with a simultaneous answer on the second probe.
    target       = 4'd11;
    sif.start    = 1'b1;
    sif.gt_valid = 1'b1;
    step();
    sif.start = 1'b0;
    chk("abort_probe1", 32'(sif.probe), 7);
    step();
    chk("abort_probe2", 32'(sif.probe), 11);
    sif.abort = 1'b1;
    sif.start = 1'b1;
    step();
    sif.abort    = 1'b0;
    sif.start    = 1'b0;
    sif.gt_valid = 1'b0;
    chk("abort_busy", 32'(sif.busy), 0);
    chk("abort_pv", 32'(sif.probe_valid), 0);
    chk("abort_probe0", 32'(sif.probe), 0);
    chk("abort_done", 32'(sif.done), 0);
    chk("abort_result", 32'(sif.result), 6);
    chk("abort_state", 32'(sif.state), 32'(IDLE));
    step();
    chk("abort_no_late_done", 32'(sif.done), 0);
    chk("abort_result_hold", 32'(sif.result), 6);
    exp_q = '{4'd7, 4'd11, 4'd9, 4'd10};
    do_search(4'd11, 0, 4'd11, 5);

    // Asynchronous reset in the middle of a search.
    target       = 4'd9;
    sif.start    = 1'b1;
    sif.gt_valid = 1'b1;
    step();
    sif.start = 1'b0;
    step();
    chk("pre_rst_probe", 32'(sif.probe), 11);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_probe", 32'(sif.probe), 0);
    chk("async_rst_pv", 32'(sif.probe_valid), 0);
    chk("async_rst_busy", 32'(sif.busy), 0);
    chk("async_rst_done", 32'(sif.done), 0);
    chk("async_rst_result", 32'(sif.result), 0);
    chk("async_rst_state", 32'(sif.state), 32'(IDLE));
    sif.gt_valid = 1'b0;
    step();
    chk("rst_held_busy", 32'(sif.busy), 0);
    rst = 1'b0;
    exp_q = '{4'd7, 4'd11, 4'd9, 4'd8};
    do_search(4'd9, 0, 4'd9, 5);

    // All targets back to back with start held high throughout.
    sif.start    = 1'b1;
    sif.gt_valid = 1'b1;
    for (int t = 0; t < 16; t++) begin
      target = 4'(t);
      step();
      chk("exh_busy", 32'(sif.busy), 1);
      repeat (4) step();
      chk("exh_done", 32'(sif.done), 1);
      chk("exh_result", 32'(sif.result), 32'(t));
      step();
      chk("exh_idle_busy", 32'(sif.busy), 0);
      chk("exh_idle_done", 32'(sif.done), 0);
    end
    sif.start    = 1'b0;
    sif.gt_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
